// File: rtl/axilite_rd_pipe_if.sv
// AXI-Lite read channel plus register-file read port, bundled for axilite_rd_pipe.
//
// Signals:
//   s_axil_ar*   AR channel (address, prot, valid/ready)
//   s_axil_r*    R channel (data, resp, valid/ready)
//   reg_rd_*     register read request/response toward the config/status file
//
// Modports:
//   slave  - the bridge itself (AXI-Lite slave, register-port requester)
//   master - the environment (interconnect plus register file)
interface axilite_rd_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 40
);
  logic [ADDR_WIDTH-1:0] s_axil_araddr;
  logic [2:0]            s_axil_arprot;
  logic                  s_axil_arvalid;
  logic                  s_axil_arready;
  logic [DATA_WIDTH-1:0] s_axil_rdata;
  logic [1:0]            s_axil_rresp;
  logic                  s_axil_rvalid;
  logic                  s_axil_rready;
  logic [ADDR_WIDTH-1:0] reg_rd_addr;
  logic                  reg_rd_en;
  logic [DATA_WIDTH-1:0] reg_rd_data;
  logic                  reg_rd_wait;
  logic                  reg_rd_ack;

  modport slave (
    input  s_axil_araddr, s_axil_arprot, s_axil_arvalid, s_axil_rready,
    output s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid,
    output reg_rd_addr, reg_rd_en,
    input  reg_rd_data, reg_rd_wait, reg_rd_ack
  );

  modport master (
    output s_axil_araddr, s_axil_arprot, s_axil_arvalid, s_axil_rready,
    input  s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid,
    input  reg_rd_addr, reg_rd_en,
    output reg_rd_data, reg_rd_wait, reg_rd_ack
  );
endinterface

// File: rtl/axilite_rd_pipe.sv
// AXI-Lite read slave bridging to the register read port of the accelerator
// config/status register file. A one-entry AR skid register feeds a two-state
// FSM that issues register reads (one per cycle when the file acks at once),
// a timeout turns a stuck read into SLVERR, out-of-range addresses answer
// DECERR without touching the register file, and a small response FIFO lets
// the R channel stall without blocking register reads.
//
// Ports:
//   clk   clock
//   rstn  asynchronous active-low reset
//   bus   axilite_rd_pipe_if.slave (AR/R channels and reg_rd_* port)
//
// DATA_WIDTH/ADDR_WIDTH must match the parameters of the connected interface.
module axilite_rd_pipe #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 40,
  parameter int                    TIMEOUT    = 16,
  parameter int                    RESP_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT = 'h1000,
  parameter logic [31:0]           ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              rstn,
  axilite_rd_pipe_if.slave  bus
);

  localparam int PTR_W = $clog2(RESP_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT);

  localparam logic [DATA_WIDTH-1:0] ERR_WORD = DATA_WIDTH'(ERR_DATA);
  localparam logic [TMR_W-1:0]      TMR_LOAD = TMR_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]      DEPTH_C  = CNT_W'(RESP_DEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {IDLE, READ} state_t;

  state_t state_q, state_d;

  logic                  out_of_reset_q;
  logic                  ar_valid_q;
  logic [ADDR_WIDTH-1:0] ar_addr_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [TMR_W-1:0]      timer_q;

  logic [DATA_WIDTH-1:0] mem_data [RESP_DEPTH];
  logic [1:0]            mem_resp [RESP_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;

  logic                  ar_in_range;
  logic                  rd_ack, rd_timeout, rd_done;
  logic                  rvalid, pop, push;
  logic [CNT_W-1:0]      occ_next;
  logic                  have_space;
  logic                  dispatch_rd, dispatch_err;
  logic [1:0]            push_resp;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  rd_en;

  // arprot carries no meaning for a register file read.
  logic unused_arprot;
  assign unused_arprot = ^bus.s_axil_arprot;

  assign rvalid = (count_q != '0);

  // Dispatch and FIFO bookkeeping. occ_next counts what the FIFO will hold
  // after this cycle's completion and pop; a new register read reserves one
  // more slot so that its response can always be pushed when it finishes.
  always_comb begin
    ar_in_range  = (ar_addr_q < ADDR_LIMIT);
    rd_ack       = (state_q == READ) && bus.reg_rd_ack;
    rd_timeout   = (state_q == READ) && !bus.reg_rd_ack && (timer_q == '0) && !bus.reg_rd_wait;
    rd_done      = rd_ack || rd_timeout;
    pop          = rvalid && bus.s_axil_rready;
    occ_next     = count_q + CNT_W'(rd_done) - CNT_W'(pop);
    have_space   = (occ_next + CNT_W'((state_q == READ) && !rd_done)) < DEPTH_C;
    dispatch_rd  = ar_valid_q && ar_in_range && have_space && ((state_q == IDLE) || rd_done);
    // Decode errors only go out from IDLE so that at most one push happens per cycle.
    dispatch_err = ar_valid_q && !ar_in_range && have_space && (state_q == IDLE);
    push         = rd_done || dispatch_err;
    push_resp    = RESP_DECERR;
    push_data    = ERR_WORD;
    if (rd_ack) begin
      push_resp = RESP_OKAY;
      push_data = bus.reg_rd_data;
    end else if (rd_timeout) begin
      push_resp = RESP_SLVERR;
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  assign bus.s_axil_arready = out_of_reset_q && (!ar_valid_q || dispatch_rd || dispatch_err);

  // Keeps arready low until the first clock edge after reset is released.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) out_of_reset_q <= 1'b0;
    else       out_of_reset_q <= 1'b1;
  end

  // AR skid entry: loaded on a handshake, cleared when its request is dispatched.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ar_valid_q <= 1'b0;
      ar_addr_q  <= '0;
    end else if (bus.s_axil_arvalid && bus.s_axil_arready) begin
      ar_valid_q <= 1'b1;
      ar_addr_q  <= bus.s_axil_araddr;
    end else if (dispatch_rd || dispatch_err) begin
      ar_valid_q <= 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: a completing read chains straight into the next pending one.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (dispatch_rd) state_d = READ;
      READ:    if (rd_done && !dispatch_rd) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    rd_en = (state_q == READ);
  end

  assign bus.reg_rd_en   = rd_en;
  assign bus.reg_rd_addr = rd_addr_q;

  // Register address and timeout counter. reg_rd_wait freezes the countdown.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_addr_q <= '0;
      timer_q   <= '0;
    end else if (dispatch_rd) begin
      rd_addr_q <= ar_addr_q;
      timer_q   <= TMR_LOAD;
    end else if (rd_done) begin
      timer_q <= '0;
    end else if ((state_q == READ) && !bus.reg_rd_wait) begin
      timer_q <= timer_q - TMR_W'(1);
    end
  end

  // Response FIFO with registered storage; the head entry drives the R channel.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < RESP_DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_resp[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_data[wr_ptr_q] <= push_data;
        mem_resp[wr_ptr_q] <= push_resp;
        wr_ptr_q           <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  assign bus.s_axil_rvalid = rvalid;
  assign bus.s_axil_rdata  = mem_data[rd_ptr_q];
  assign bus.s_axil_rresp  = mem_resp[rd_ptr_q];

endmodule

// File: tb/tb_axilite_rd_pipe.sv
// Self-checking bench for axilite_rd_pipe. A register-file responder answers
// reg_rd_en combinationally; a scoreboard of expected R beats is filled in AR
// order from a behavioural model of the response rules, and every accepted R
// beat is compared against its head. Directed scenarios cover latency,
// streaming, back-pressure, timeout, decode error and mid-read reset; a
// randomized phase mixes all of them.
module tb_axilite_rd_pipe;

  localparam int DW = 32;
  localparam int AW = 40;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  axilite_rd_pipe_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  axilite_rd_pipe #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(16), .RESP_DEPTH(4),
    .ADDR_LIMIT(40'h1000), .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail = 0;

  logic [33:0] exp_q[$];
  logic [39:0] ar_q[$];

  int cyc, hs_cyc, en_cycles, acks, resp_count;
  int first_en, last_en, first_resp, last_resp;
  int decode_leak, en_run, hold_viol;
  logic ack_allow, no_ack_expect, use_fixed, prev_hold;
  logic [31:0] fixed_data;
  logic [33:0] prev_r;

  // Contents of the modelled register file.
  function automatic logic [31:0] reg_value(input logic [39:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0F0F_3C3C;
  endfunction

  // Expected {rresp, rdata} for a request, from the bridge's response rules.
  function automatic logic [33:0] model_resp(input logic [39:0] a);
    if (a >= 40'h1000)  return {2'b11, 32'hDEAD_BEEF};
    if (no_ack_expect)  return {2'b10, 32'hDEAD_BEEF};
    if (use_fixed)      return {2'b00, fixed_data};
    return {2'b00, reg_value(a)};
  endfunction

  assign bus.reg_rd_ack  = bus.reg_rd_en && ack_allow;
  assign bus.reg_rd_data = use_fixed ? fixed_data : reg_value(bus.reg_rd_addr);

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic resetCounters();
    en_cycles = 0; acks = 0; resp_count = 0; hs_cyc = -1;
    first_en = -1; last_en = -1; first_resp = -1; last_resp = -1;
  endtask

  // One clock: drive inputs just after the falling edge, let the design settle,
  // then record what the coming rising edge will register.
  task automatic applyStimulus(input logic r_rdy, input logic ack_in, input logic wt, input logic ar_gap);
    @(negedge clk);
    cyc++;
    if (ar_q.size() == 0)                     bus.s_axil_arvalid = 1'b0;
    else if (!bus.s_axil_arvalid && ar_gap)   bus.s_axil_arvalid = 1'b0;
    else                                      bus.s_axil_arvalid = 1'b1;
    bus.s_axil_araddr  = (ar_q.size() != 0) ? ar_q[0] : '0;
    bus.s_axil_arprot  = 3'($urandom_range(0, 7));
    bus.s_axil_rready  = r_rdy;
    bus.reg_rd_wait    = wt;
    ack_allow          = ack_in;
    #1;
    if (prev_hold && !(bus.s_axil_rvalid && ({bus.s_axil_rresp, bus.s_axil_rdata} == prev_r)))
      hold_viol++;
    prev_hold = bus.s_axil_rvalid && !bus.s_axil_rready;
    prev_r    = {bus.s_axil_rresp, bus.s_axil_rdata};
    if (bus.reg_rd_en) begin
      en_cycles++;
      if (first_en < 0) first_en = cyc;
      last_en = cyc;
      if (bus.reg_rd_addr >= 40'h1000) decode_leak++;
      if (bus.reg_rd_ack) begin acks++; en_run = 0; end
      else en_run++;
    end else begin
      en_run = 0;
    end
    if (bus.s_axil_arvalid && bus.s_axil_arready) begin
      exp_q.push_back(model_resp(ar_q[0]));
      void'(ar_q.pop_front());
      hs_cyc = cyc;
    end
    if (bus.s_axil_rvalid && bus.s_axil_rready) begin
      resp_count++;
      if (first_resp < 0) first_resp = cyc;
      last_resp = cyc;
      if (exp_q.size() == 0) checkOutput("unexpected_resp", 1, 0);
      else checkOutput("r_beat", {bus.s_axil_rresp, bus.s_axil_rdata}, exp_q.pop_front());
    end
  endtask

  task automatic runUntilIdle(input string tag, input logic ack_in, input int budget);
    int n = 0;
    while ((ar_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      applyStimulus(1'b1, ack_in, 1'b0, 1'b0);
      n++;
    end
    checkOutput({tag, "_drained"}, 64'(ar_q.size() + exp_q.size()), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    cyc = 0; decode_leak = 0; en_run = 0; hold_viol = 0;
    ack_allow = 1'b0; no_ack_expect = 1'b0; use_fixed = 1'b0; fixed_data = '0;
    prev_hold = 1'b0; prev_r = '0;
    bus.s_axil_araddr = '0; bus.s_axil_arprot = '0; bus.s_axil_arvalid = 1'b0;
    bus.s_axil_rready = 1'b0; bus.reg_rd_wait = 1'b0;
    resetCounters();

    // Reset values while rstn is held low, arready once released.
    rstn = 1'b0;
    @(negedge clk); #1;
    checkOutput("rst_arready", bus.s_axil_arready, 0);
    checkOutput("rst_rvalid",  bus.s_axil_rvalid, 0);
    checkOutput("rst_rd_en",   bus.reg_rd_en, 0);
    checkOutput("rst_rdata",   bus.s_axil_rdata, 0);
    checkOutput("rst_rresp",   bus.s_axil_rresp, 0);
    checkOutput("rst_rd_addr", bus.reg_rd_addr, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk); #1;
    checkOutput("arready_after_release", bus.s_axil_arready, 1);

    // Single read with immediate ack: reg_rd_en two edges, rvalid three edges after AR.
    $display("[TB] single read");
    resetCounters();
    use_fixed = 1'b1; fixed_data = 32'h1234;
    ar_q.push_back(40'h10);
    runUntilIdle("single", 1'b1, 20);
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("single_en_latency", 64'(first_en - hs_cyc), 2);
    checkOutput("single_r_latency",  64'(first_resp - hs_cyc), 3);
    checkOutput("single_en_cycles",  64'(en_cycles), 1);
    checkOutput("single_resp_count", 64'(resp_count), 1);
    use_fixed = 1'b0;

    // Eight back-to-back reads stream at one per cycle.
    $display("[TB] back-to-back");
    resetCounters();
    for (int i = 0; i < 8; i++) ar_q.push_back(40'(i * 4));
    runUntilIdle("b2b", 1'b1, 40);
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("b2b_en_cycles", 64'(en_cycles), 8);
    checkOutput("b2b_en_span",   64'(last_en - first_en), 7);
    checkOutput("b2b_r_span",    64'(last_resp - first_resp), 7);
    checkOutput("b2b_resp_count", 64'(resp_count), 8);

    // R channel stalled: four reads fill the FIFO, one waits in the skid entry.
    $display("[TB] back-pressure");
    resetCounters();
    for (int i = 0; i < 6; i++) ar_q.push_back(40'h100 + 40'(i * 4));
    repeat (14) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("bp_completions", 64'(acks), 4);
    checkOutput("bp_arready", bus.s_axil_arready, 0);
    checkOutput("bp_ar_left", 64'(ar_q.size()), 1);
    checkOutput("bp_no_resp", 64'(resp_count), 0);
    runUntilIdle("bp", 1'b1, 40);
    checkOutput("bp_resp_count", 64'(resp_count), 6);
    checkOutput("bp_total_acks", 64'(acks), 6);

    // Timeout: no ack gives sixteen request cycles and SLVERR.
    $display("[TB] timeout");
    resetCounters();
    no_ack_expect = 1'b1;
    ar_q.push_back(40'h20);
    repeat (30) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("to_en_cycles", 64'(en_cycles), 16);
    checkOutput("to_resp_count", 64'(resp_count), 1);
    resetCounters();
    ar_q.push_back(40'h24);
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b0, (i >= 5 && i < 15), 1'b0);
    checkOutput("to_wait_en_cycles", 64'(en_cycles), 26);
    checkOutput("to_wait_resp_count", 64'(resp_count), 1);
    no_ack_expect = 1'b0;

    // Decode error sandwiched between in-range reads keeps AR order.
    $display("[TB] decode error");
    resetCounters();
    decode_leak = 0;
    ar_q.push_back(40'h30); ar_q.push_back(40'h1000); ar_q.push_back(40'h34);
    runUntilIdle("dec", 1'b1, 30);
    checkOutput("dec_no_reg_read", 64'(decode_leak), 0);
    checkOutput("dec_en_cycles", 64'(en_cycles), 2);
    checkOutput("dec_resp_count", 64'(resp_count), 3);

    // Reset pulse mid-read with two responses queued.
    $display("[TB] reset mid-read");
    resetCounters();
    ar_q.push_back(40'h50); ar_q.push_back(40'h54);
    repeat (4) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    ar_q.push_back(40'h58);
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("mid_pre_rd_en",  bus.reg_rd_en, 1);
    checkOutput("mid_pre_rvalid", bus.s_axil_rvalid, 1);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("mid_rst_rvalid",  bus.s_axil_rvalid, 0);
    checkOutput("mid_rst_rd_en",   bus.reg_rd_en, 0);
    checkOutput("mid_rst_arready", bus.s_axil_arready, 0);
    checkOutput("mid_rst_rd_addr", bus.reg_rd_addr, 0);
    checkOutput("mid_rst_rdata",   bus.s_axil_rdata, 0);
    exp_q.delete(); ar_q.delete();
    bus.s_axil_arvalid = 1'b0;
    prev_hold = 1'b0; en_run = 0;
    @(negedge clk);
    rstn = 1'b1;
    resetCounters();
    ar_q.push_back(40'h60);
    runUntilIdle("mid", 1'b1, 20);
    repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("mid_fresh_resp_count", 64'(resp_count), 1);

    // Randomized traffic against the scoreboard.
    $display("[TB] random traffic");
    resetCounters();
    decode_leak = 0;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 7) != 0) ar_q.push_back({28'h0, 10'($urandom_range(0, 1023)), 2'b00});
      else if ($urandom_range(0, 1) != 0) ar_q.push_back(40'h1000 + 40'($urandom_range(0, 'hFFFF)));
      else ar_q.push_back({8'hA5, 32'($urandom)});
    end
    for (int n = 0; n < 2000 && (ar_q.size() != 0 || exp_q.size() != 0); n++)
      applyStimulus($urandom_range(0, 3) != 0, ($urandom_range(0, 2) != 0) || (en_run >= 8),
                    $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0);
    checkOutput("rnd_drained", 64'(ar_q.size() + exp_q.size()), 0);
    checkOutput("rnd_resp_count", 64'(resp_count), 80);
    checkOutput("rnd_no_reg_read_oob", 64'(decode_leak), 0);
    checkOutput("r_hold_stable", 64'(hold_viol), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
